// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite write path (stamp writer, scan counter)
// and the renderer's draw qualification.
package sprite_pkg;

  // Stamp writer sequencing; READ is only reachable in the read-modify-write build.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } stamp_state_t;

  // Pixel value the renderer treats as see-through; also the erase colour.
  localparam int COLR_TRANSPARENT = 0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/stamp_scan_ctr.sv
// Row-major i/j offset counter for a STAMP_W x STAMP_H patch.
// 'clr' restarts at (0,0); 'adv' steps one pixel; 'last' flags the final pixel.
module stamp_scan_ctr
  import sprite_pkg::*;
#(
  parameter int STAMP_W = 3,
  parameter int STAMP_H = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           adv,
  output logic [ctr_width(STAMP_W)-1:0]  i,
  output logic [ctr_width(STAMP_H)-1:0]  j,
  output logic                           last
);

  localparam int IW = ctr_width(STAMP_W);
  localparam int JW = ctr_width(STAMP_H);
  localparam logic [IW-1:0] I_LAST = IW'(STAMP_W - 1);
  localparam logic [JW-1:0] J_LAST = JW'(STAMP_H - 1);

  logic [IW-1:0] i_r;
  logic [JW-1:0] j_r;
  logic          i_wrap_s;
  logic          last_s;

  assign i_wrap_s = (i_r == I_LAST);
  assign last_s   = i_wrap_s && (j_r == J_LAST);

  // Offset registers: restart on clr, otherwise step column then row on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r <= {IW{1'b0}};
      j_r <= {JW{1'b0}};
    end else if (clr) begin
      i_r <= {IW{1'b0}};
      j_r <= {JW{1'b0}};
    end else if (adv) begin
      if (i_wrap_s) begin
        i_r <= {IW{1'b0}};
        if (last_s) begin
          j_r <= {JW{1'b0}};
        end else begin
          j_r <= j_r + JW'(1'b1);
        end
      end else begin
        i_r <= i_r + IW'(1'b1);
      end
    end else begin
      i_r <= i_r;
      j_r <= j_r;
    end
  end

  assign i    = i_r;
  assign j    = j_r;
  assign last = last_s;

endmodule

// File: rtl/sprite_stamp_writer.sv
// Stamps a STAMP_W x STAMP_H patch of one colour into a sprite bitmap RAM at
// sprite-local (possibly negative) coordinates, clipping to the bitmap.
// Optional build macro SPRITE_STAMP_RMW_EN: read each in-range pixel first,
// rewrite only non-transparent ones and count them in hit_cnt.
module sprite_stamp_writer
  import sprite_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int HEIGHT    = 10,
  parameter int COLR_BITS = 12,
  parameter int CORDW     = 16,
  parameter int STAMP_W   = 3,
  parameter int STAMP_H   = 3,
  parameter int ADDRW     = $clog2(WIDTH * HEIGHT)
) (
  input  logic                                  clk_pix,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic signed [CORDW-1:0]               req_x,
  input  logic signed [CORDW-1:0]               req_y,
  input  logic [COLR_BITS-1:0]                  req_colr,
  output logic                                  wr_en,
  output logic [ADDRW-1:0]                      wr_addr,
  output logic [COLR_BITS-1:0]                  wr_data,
  output logic [ADDRW-1:0]                      rd_addr,
  input  logic [COLR_BITS-1:0]                  rd_data,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(STAMP_W*STAMP_H+1)-1:0]  hit_cnt
);

  localparam int IW   = ctr_width(STAMP_W);
  localparam int JW   = ctr_width(STAMP_H);
  localparam int HITW = $clog2(STAMP_W * STAMP_H + 1);
  localparam logic signed [CORDW:0] WIDTH_S  = (CORDW+1)'(WIDTH);
  localparam logic signed [CORDW:0] HEIGHT_S = (CORDW+1)'(HEIGHT);

  stamp_state_t state_r;
  stamp_state_t state_s;

  logic signed [CORDW-1:0] x_r;
  logic signed [CORDW-1:0] y_r;
  logic [COLR_BITS-1:0]    colr_r;

  logic                    accept_s;
  logic                    ctr_clr_s;
  logic                    ctr_adv_s;
  logic [IW-1:0]           i_s;
  logic [JW-1:0]           j_s;
  logic                    last_s;

  logic signed [CORDW:0]   px_s;
  logic signed [CORDW:0]   py_s;
  logic [ADDRW-1:0]        px_a_s;
  logic [ADDRW-1:0]        py_a_s;
  logic                    in_range_s;
  logic [ADDRW-1:0]        addr_s;
  logic                    rd_nz_s;

  assign accept_s = (state_r == IDLE) && req_valid;

  stamp_scan_ctr #(
    .STAMP_W (STAMP_W),
    .STAMP_H (STAMP_H)
  ) u_scan (
    .clk   (clk_pix),
    .rst_n (rst_n),
    .clr   (ctr_clr_s),
    .adv   (ctr_adv_s),
    .i     (i_s),
    .j     (j_s),
    .last  (last_s)
  );

  // Pixel coordinates are widened by one bit so x+i cannot overflow.
  assign px_s = {x_r[CORDW-1], x_r} + {{(CORDW+1-IW){1'b0}}, i_s};
  assign py_s = {y_r[CORDW-1], y_r} + {{(CORDW+1-JW){1'b0}}, j_s};

  assign in_range_s = !px_s[CORDW] && (px_s < WIDTH_S) &&
                      !py_s[CORDW] && (py_s < HEIGHT_S);

  // Only meaningful when in range, where both coordinates fit in ADDRW bits.
  assign px_a_s = px_s[ADDRW-1:0];
  assign py_a_s = py_s[ADDRW-1:0];
  assign addr_s = py_a_s * ADDRW'(WIDTH) + px_a_s;

`ifdef SPRITE_STAMP_RMW_EN
  assign rd_nz_s = (rd_data != COLR_BITS'(COLR_TRANSPARENT));
`else
  logic rd_data_unused_s;
  assign rd_data_unused_s = ^rd_data;
  assign rd_nz_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture: coordinates and colour are frozen for the whole stamp.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= {CORDW{1'b0}};
      y_r    <= {CORDW{1'b0}};
      colr_r <= {COLR_BITS{1'b0}};
    end else if (accept_s) begin
      x_r    <= req_x;
      y_r    <= req_y;
      colr_r <= req_colr;
    end else begin
      x_r    <= x_r;
      y_r    <= y_r;
      colr_r <= colr_r;
    end
  end

  // Next state and scan-counter control.
  always_comb begin
    state_s   = state_r;
    ctr_clr_s = 1'b0;
    ctr_adv_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          ctr_clr_s = 1'b1;
`ifdef SPRITE_STAMP_RMW_EN
          state_s   = READ;
`else
          state_s   = WRITE;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        // Off-bitmap pixels are skipped here in a single cycle.
        if (in_range_s) begin
          state_s = WRITE;
        end else begin
          ctr_adv_s = 1'b1;
          state_s   = last_s ? DONE : READ;
        end
      end
      WRITE: begin
        ctr_adv_s = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
`ifdef SPRITE_STAMP_RMW_EN
          state_s = READ;
`else
          state_s = WRITE;
`endif
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Port decode from registered state; nothing here looks at req_*.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = {ADDRW{1'b0}};
    wr_data   = {COLR_BITS{1'b0}};
    rd_addr   = {ADDRW{1'b0}};
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
      end
      READ: begin
        busy = 1'b1;
`ifdef SPRITE_STAMP_RMW_EN
        if (in_range_s) begin
          rd_addr = addr_s;
        end else begin
          rd_addr = {ADDRW{1'b0}};
        end
`endif
      end
      WRITE: begin
        busy = 1'b1;
        if (in_range_s && rd_nz_s) begin
          wr_en   = 1'b1;
          wr_addr = addr_s;
          wr_data = colr_r;
        end else begin
          wr_en   = 1'b0;
          wr_addr = {ADDRW{1'b0}};
          wr_data = {COLR_BITS{1'b0}};
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

`ifdef SPRITE_STAMP_RMW_EN
  logic [HITW-1:0] hit_cnt_r;

  // Count non-transparent pixels overwritten; cleared on accept, held after done.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r <= {HITW{1'b0}};
    end else if (accept_s) begin
      hit_cnt_r <= {HITW{1'b0}};
    end else if ((state_r == WRITE) && wr_en) begin
      hit_cnt_r <= hit_cnt_r + HITW'(1'b1);
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  assign hit_cnt = hit_cnt_r;
`else
  assign hit_cnt = {HITW{1'b0}};
`endif

endmodule

// File: tb/tb_sprite_stamp_writer.sv
// Randomized self-checking bench for sprite_stamp_writer against a
// pixel-list reference model and a shadow copy of the sprite RAM.
module tb_sprite_stamp_writer;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int CB = 12;
  localparam int SW = 3;
  localparam int SH = 3;
  localparam int AW = 7;

  typedef struct {
    logic        en;
    logic        rd;
    int          addr;
    logic [11:0] data;
  } ev_t;

  logic               clk_pix = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic signed [15:0] req_x;
  logic signed [15:0] req_y;
  logic [CB-1:0]      req_colr;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [CB-1:0]      wr_data;
  logic [AW-1:0]      rd_addr;
  logic [CB-1:0]      rd_data;
  logic               busy;
  logic               done;
  logic [3:0]         hit_cnt;

  logic               pre_en;
  logic [AW-1:0]      pre_addr;
  logic [CB-1:0]      pre_data;

  logic [CB-1:0] ram     [0:W*H-1];
  logic [CB-1:0] ref_mem [0:W*H-1];

  int checks = 0;
  int errors = 0;

  always #5 clk_pix = ~clk_pix;

  sprite_stamp_writer dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_colr  (req_colr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .hit_cnt   (hit_cnt)
  );

  // Simple dual-port sprite RAM with 1-cycle read latency plus a preload port.
  always @(posedge clk_pix) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (wr_en) ram[wr_addr] <= wr_data;
    rd_data <= ram[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // Expected per-cycle activity of one stamp, from the pre-stamp RAM image.
  task automatic build(input int x, input int y, input int c, output ev_t q[$]);
    ev_t e;
    q = {};
    for (int jj = 0; jj < SH; jj++) begin
      for (int ii = 0; ii < SW; ii++) begin
        int px, py, a;
        bit inr;
        px  = x + ii;
        py  = y + jj;
        inr = (px >= 0) && (px < W) && (py >= 0) && (py < H);
        a   = inr ? (py * W + px) : 0;
`ifdef SPRITE_STAMP_RMW_EN
        if (inr) begin
          e = '{en: 1'b0, rd: 1'b1, addr: a, data: 12'h000};
          q.push_back(e);
          e = '{en: (ref_mem[a] != 12'h000), rd: 1'b0, addr: a, data: 12'(c)};
          q.push_back(e);
        end else begin
          e = '{en: 1'b0, rd: 1'b0, addr: 0, data: 12'h000};
          q.push_back(e);
        end
`else
        e = '{en: inr, rd: 1'b0, addr: a, data: 12'(c)};
        q.push_back(e);
`endif
      end
    end
  endtask

  // Issue one stamp and check every cycle until ready returns.
  // hold: keep req_valid high afterwards with the next request (nx,ny,nc).
  // abort_at: pull rst_n low at that cycle instead of completing.
  task automatic run_stamp(input int x, input int y, input int c,
                           input bit hold = 1'b0, input int nx = 0, input int ny = 0,
                           input int nc = 0, input int abort_at = 0);
    ev_t q[$];
    int  hits;
    int  exp_hits;
    build(x, y, c, q);
    req_valid = 1'b1;
    req_x     = 16'(x);
    req_y     = 16'(y);
    req_colr  = 12'(c);
    check("ready_before_accept", {31'd0, req_ready}, 32'd1);
    tick();
    if (hold) begin
      req_x    = 16'(nx);
      req_y    = 16'(ny);
      req_colr = 12'(nc);
    end else begin
      req_valid = 1'b0;
    end
    hits = 0;
    for (int k = 0; k < q.size(); k++) begin
      if (abort_at == k + 1) begin
        rst_n = 1'b0;
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        for (int m = 0; m < k; m++) begin
          if (q[m].en) ref_mem[q[m].addr] = q[m].data;
        end
        tick();
        check("rst_no_done", {31'd0, done}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_post_done", {31'd0, done}, 32'd0);
        return;
      end
      check("wr_en", {31'd0, wr_en}, {31'd0, q[k].en});
      if (q[k].en) begin
        check("wr_addr", {25'd0, wr_addr}, q[k].addr);
        check("wr_data", {20'd0, wr_data}, {20'd0, q[k].data});
        hits++;
      end
`ifdef SPRITE_STAMP_RMW_EN
      if (q[k].rd) check("rd_addr", {25'd0, rd_addr}, q[k].addr);
`endif
      check("busy", {31'd0, busy}, 32'd1);
      check("ready_low", {31'd0, req_ready}, 32'd0);
      check("done_early", {31'd0, done}, 32'd0);
      tick();
    end
`ifdef SPRITE_STAMP_RMW_EN
    exp_hits = hits;
`else
    exp_hits = 0;
`endif
    check("done", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_wr_en", {31'd0, wr_en}, 32'd0);
    check("done_ready", {31'd0, req_ready}, 32'd0);
    check("hit_cnt", {28'd0, hit_cnt}, exp_hits);
    tick();
    check("ready_after", {31'd0, req_ready}, 32'd1);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("hit_hold", {28'd0, hit_cnt}, exp_hits);
    for (int m = 0; m < q.size(); m++) begin
      if (q[m].en) ref_mem[q[m].addr] = q[m].data;
    end
  endtask

  initial begin
    int x, y, c, nx, ny, nc;
    bit pend;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_x     = 16'sd0;
    req_y     = 16'sd0;
    req_colr  = 12'h000;
    pre_en    = 1'b0;
    pre_addr  = 7'd0;
    pre_data  = 12'h000;

    // Preload under reset: 0 and 1 non-transparent, rest of the 3x3 at origin clear.
    for (int a = 0; a < W * H; a++) begin
      logic [CB-1:0] v;
      if (a == 0) v = 12'h5A5;
      else if (a == 1) v = 12'h0F0;
      else if ((a % W) < 3 && (a / W) < 3) v = 12'h000;
      else if ($urandom_range(0, 2) == 0) v = 12'h000;
      else v = 12'($urandom_range(1, 4095));
      pre_en   = 1'b1;
      pre_addr = 7'(a);
      pre_data = v;
      ref_mem[a] = v;
      tick();
    end
    pre_en = 1'b0;

    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("reset_wr_data", {20'd0, wr_data}, 32'd0);
    check("reset_rd_addr", {25'd0, rd_addr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hit_cnt", {28'd0, hit_cnt}, 32'd0);

    @(negedge clk_pix);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_stamp(0, 0, 12'h321);
    run_stamp(4, 4, 0);
    run_stamp(-1, -1, 12'hABC);
    run_stamp(10, 3, 12'h444);
    run_stamp(-3, 0, 12'h555);
    run_stamp(2, 7, 12'h111, 1'b1, 6, -2, 12'h222);
    run_stamp(6, -2, 12'h222);
    run_stamp(4, 4, 12'h777, 1'b0, 0, 0, 0, 5);
    run_stamp(1, 1, 12'h0AA);
    run_stamp(8, 8, 12'h9F3);

    // Randomized stamps, some back-to-back with req_valid held.
    pend = 1'b0;
    nx = 0; ny = 0; nc = 0;
    for (int r = 0; r < 40; r++) begin
      if (pend) begin
        x = nx; y = ny; c = nc;
      end else begin
        x = int'($urandom_range(0, 17)) - 5;
        y = int'($urandom_range(0, 17)) - 5;
        c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 4095));
      end
      pend = ($urandom_range(0, 2) == 0);
      nx = int'($urandom_range(0, 17)) - 5;
      ny = int'($urandom_range(0, 17)) - 5;
      nc = int'($urandom_range(0, 4095));
      run_stamp(x, y, c, pend, nx, ny, nc);
    end
    if (pend) run_stamp(nx, ny, nc);

    // Let the last write land, then compare the whole bitmap.
    tick();
    for (int a = 0; a < W * H; a++) begin
      check("ram_image", {20'd0, ram[a]}, {20'd0, ref_mem[a]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_stamp_writer.md
Name: sprite_stamp_writer

Overview:
- Write-side companion to the sprite pixel-read path.
- Stamps a small rectangular patch of one colour into a sprite bitmap RAM at sprite-local coordinates. Typical use: bunker erosion, where a bullet hit clears pixels to 0, which the renderer treats as transparent.
- Drives the write port of a simple dual-port sprite RAM. The renderer keeps the read port, so no arbitration with display timing is needed.
- Accepts one stamp request at a time via a valid/ready handshake. Pulses done on completion.

Parameters:
- WIDTH, 10, sprite bitmap width in pixels
- HEIGHT, 10, sprite bitmap height in pixels
- COLR_BITS, 12, bits per pixel word in sprite RAM
- CORDW, 16, width of signed local coordinate inputs
- STAMP_W, 3, stamp width in pixels (>=1)
- STAMP_H, 3, stamp height in pixels (>=1)
- ADDRW, $clog2(WIDTH*HEIGHT), RAM address width

Ports:
- clk_pix  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  stamp request present
- req_ready  out  1  block can accept a request
- req_x  in  CORDW signed  stamp top-left x, sprite-local (may be negative)
- req_y  in  CORDW signed  stamp top-left y, sprite-local (may be negative)
- req_colr  in  COLR_BITS  value to write (0 = erase/transparent)
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDRW  RAM write address, row-major py*WIDTH+px
- wr_data  out  COLR_BITS  RAM write data
- rd_addr  out  ADDRW  RAM read address (RMW feature only)
- rd_data  in  COLR_BITS  RAM read data, 1-cycle synchronous latency
- busy  out  1  stamp in progress
- done  out  1  one-cycle pulse when a stamp finishes
- hit_cnt  out  $clog2(STAMP_W*STAMP_H+1)  non-transparent pixels overwritten by last stamp

Behaviour:
- Clock and reset: one clock, clk_pix. rst_n is asynchronous and active-low.
- Reset values: state IDLE; req_ready=1; wr_en=0; wr_addr=0; wr_data=0; rd_addr=0; busy=0; done=0; hit_cnt=0.
- States: IDLE, WRITE, DONE (plus READ with the feature).
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch x, y, colr; clear offset counters i=j=0 and hit_cnt; go to WRITE.
  - req_ready=0 in every state except IDLE. Requests presented while busy wait; they are not dropped.
- WRITE, one cycle per stamp pixel:
  - px=x+i, py=y+j, computed in CORDW+1 signed to avoid overflow.
  - If 0<=px<WIDTH and 0<=py<HEIGHT: wr_en=1, wr_addr=py*WIDTH+px, wr_data=colr. Otherwise wr_en=0; the pixel is skipped but still consumes its cycle.
  - Scan order is row-major: i increments; when i wraps at STAMP_W-1, i=0 and j increments. After pixel (STAMP_W-1, STAMP_H-1), go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency, base build:
  - Accept at cycle 0.
  - Writes on cycles 1..N, where N=STAMP_W*STAMP_H.
  - done on cycle N+1.
  - req_ready on cycle N+2.
- Timing paths:
  - wr_* and busy are derived only from registered state; there is no combinational path from req_* to wr_*.
  - busy=1 in WRITE/READ.
- Boundary cases:
  - A stamp entirely off-bitmap produces zero writes and still completes in the same cycle count.
  - A stamp partially off-bitmap writes only the in-range pixels. Addresses never wrap and never exceed WIDTH*HEIGHT-1.
- Reset mid-stamp: immediately returns to IDLE with wr_en=0. The partial stamp stays in RAM and no done is issued.
- Without the feature: rd_addr is held 0, rd_data is ignored, and hit_cnt is held 0.

Optional Feature:
- Macro: SPRITE_STAMP_RMW_EN.
- When defined, each in-range pixel uses a READ cycle followed by a WRITE cycle:
  - READ cycle: rd_addr=addr.
  - Following WRITE cycle: if rd_data!=0, assert wr_en and increment hit_cnt; if rd_data==0, wr_en=0, so already-transparent pixels are not rewritten.
- Out-of-range pixels take 1 cycle, with no read and no write.
- hit_cnt is valid from the done cycle and holds until the next accept.
- When undefined: behaviour as in the base build.

Decomposition:
- Shared package sprite_pkg:
  - stamp_state_t enum (IDLE, READ, WRITE, DONE).
  - COLR_TRANSPARENT=0 constant, also used by the renderer's drawing qualification.
- Sub-module stamp_scan_ctr: the i/j row-major offset counter with last-pixel flag. Natural to split out and reusable for sprite-clear sweeps.

Test Plan:
- Centre stamp, 10x10 bitmap, 3x3 stamp: req (4,4) colr=0 → 9 writes at addresses 44,45,46,54,55,56,64,65,66 on cycles 1..9; done on cycle 10; ready on cycle 11.
- Corner clip: req (-1,-1) → writes only 0,1,10,11; wr_en low on the other 5 cycles; done still on cycle 10.
- Fully off-bitmap: req (10,3) and req (-3,0) → zero wr_en; done on cycle 10 each.
- Back-to-back: req_valid held high with two requests → second accepted only on cycle 11; no overlap of wr_en streams.
- Reset mid-stamp: rst_n low at cycle 5 → wr_en drops asynchronously; no done; after release req_ready=1 and a new stamp runs normally.
- RMW build (SPRITE_STAMP_RMW_EN), stamp at (0,0) over preloaded addresses 0,1,2,10,11,12,20,21,22 (pixels 0,1 nonzero, rest 0) → exactly 2 writes; hit_cnt=2 at done; done on cycle 19.
